// File: rtl/button_event_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : button_event_ctrl                                               |
// | Purpose  : Debounced buttons feeding a round-robin scheduled event FIFO.   |
// |            Optional long-press events when LONG_PRESS_EN is defined.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module button_event_ctrl #(
    parameter int NUM_BTN     = 4,
    parameter int DB_CYCLES   = 50000,
    parameter int LONG_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    output logic [4:0]         evt_data,
    input  logic               evt_ready,
    output logic [3:0]         evt_count,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam logic [1:0]  c_TYPE_PRESS   = 2'b00;
    localparam logic [1:0]  c_TYPE_RELEASE = 2'b01;
    localparam logic [1:0]  c_TYPE_LONG    = 2'b10;
    localparam logic [15:0] c_DB_LAST      = 16'(DB_CYCLES - 1);
    localparam logic [3:0]  c_FIFO_DEPTH   = 4'd8;

    logic [NUM_BTN-1:0] r_sync1_q, r_sync2_q;
    logic [NUM_BTN-1:0] r_state_q, w_state_d;
    logic [15:0]        r_db_cnt_q [NUM_BTN];
    logic [15:0]        w_db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] w_toggle;
    logic [NUM_BTN-1:0] w_long;
    logic [NUM_BTN-1:0] w_new_vld;
    logic [1:0]         w_new_type [NUM_BTN];
    logic [NUM_BTN-1:0] r_pend_vld_q, w_pend_vld_d;
    logic [1:0]         r_pend_type_q [NUM_BTN];
    logic [1:0]         w_pend_type_d [NUM_BTN];
    logic [2:0]         r_rr_q, w_rr_d;
    logic               w_hi_found;
    logic [2:0]         w_hi_idx, w_lo_idx, w_grant_idx;
    logic [NUM_BTN-1:0] w_gnt;
    logic               w_push, w_pop, w_drop;
    logic [4:0]         w_push_data;
    logic [4:0]         r_fifo_q [8];
    logic [4:0]         w_fifo_d [8];
    logic [2:0]         r_wr_ptr_q, w_wr_ptr_d, r_rd_ptr_q, w_rd_ptr_d;
    logic [3:0]         r_count_q, w_count_d;
    logic               r_ovf_q, w_ovf_d;

    // Debounce: the counter tracks consecutive cycles of disagreement.
    always_comb begin
        w_state_d = r_state_q;
        w_toggle  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_db_cnt_d[i] = 16'd0;
            if (r_sync2_q[i] != r_state_q[i]) begin
                if (r_db_cnt_q[i] == c_DB_LAST) begin
                    w_toggle[i]  = 1'b1;
                    w_state_d[i] = ~r_state_q[i];
                end else begin
                    w_db_cnt_d[i] = r_db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam logic [23:0] c_LONG_LAST = 24'(LONG_CYCLES - 1);
    logic [23:0] r_hold_q [NUM_BTN];
    logic [23:0] w_hold_d [NUM_BTN];

    // A releasing button stops counting, so long and release never coincide.
    always_comb begin
        w_long = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_hold_d[i] = 24'd0;
            if (r_state_q[i] && !w_toggle[i]) begin
                if (r_hold_q[i] != c_LONG_LAST) begin
                    w_hold_d[i] = r_hold_q[i] + 24'd1;
                    w_long[i]   = (r_hold_q[i] == c_LONG_LAST - 24'd1);
                end else begin
                    w_hold_d[i] = r_hold_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) r_hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) r_hold_q[i] <= w_hold_d[i];
        end
    end
`else
    assign w_long = '0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            w_new_vld[i]  = w_toggle[i] | w_long[i];
            w_new_type[i] = w_toggle[i] ? (r_state_q[i] ? c_TYPE_RELEASE : c_TYPE_PRESS)
                                        : c_TYPE_LONG;
        end
    end

    // Round-robin: lowest pending index at/after rr, else lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = 3'd0;
        w_lo_idx   = 3'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_pend_vld_q[i]) begin
                w_lo_idx = 3'(i);
                if (3'(i) >= r_rr_q) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 3'(i);
                end
            end
        end
        w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_push      = (r_count_q != c_FIFO_DEPTH) && (|r_pend_vld_q);
        w_gnt       = '0;
        w_push_data = 5'd0;
        w_drop      = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_pend_vld_d[i]  = r_pend_vld_q[i];
            w_pend_type_d[i] = r_pend_type_q[i];
            if (w_push && (w_grant_idx == 3'(i))) begin
                w_gnt[i]        = 1'b1;
                w_push_data     = {r_pend_type_q[i], 3'(i)};
                w_pend_vld_d[i] = 1'b0;
            end
            if (w_new_vld[i]) begin
                if (r_pend_vld_q[i] && !w_gnt[i]) begin
                    w_drop = 1'b1;
                end else begin
                    w_pend_vld_d[i]  = 1'b1;
                    w_pend_type_d[i] = w_new_type[i];
                end
            end
        end
        w_rr_d = r_rr_q;
        if (w_push) begin
            w_rr_d = (w_grant_idx == 3'(NUM_BTN - 1)) ? 3'd0 : w_grant_idx + 3'd1;
        end
    end

    always_comb begin
        w_pop = (r_count_q != 4'd0) && evt_ready;
        for (int k = 0; k < 8; k++) w_fifo_d[k] = r_fifo_q[k];
        if (w_push) w_fifo_d[r_wr_ptr_q] = w_push_data;
        w_wr_ptr_d = r_wr_ptr_q + {2'd0, w_push};
        w_rd_ptr_d = r_rd_ptr_q + {2'd0, w_pop};
        w_count_d  = r_count_q + {3'd0, w_push} - {3'd0, w_pop};
        w_ovf_d    = w_drop | (r_ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1_q    <= '0;
            r_sync2_q    <= '0;
            r_state_q    <= '0;
            r_pend_vld_q <= '0;
            r_rr_q       <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_ovf_q      <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt_q[i]    <= '0;
                r_pend_type_q[i] <= '0;
            end
            for (int k = 0; k < 8; k++) r_fifo_q[k] <= '0;
        end else begin
            r_sync1_q    <= btn;
            r_sync2_q    <= r_sync1_q;
            r_state_q    <= w_state_d;
            r_pend_vld_q <= w_pend_vld_d;
            r_rr_q       <= w_rr_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            r_ovf_q      <= w_ovf_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt_q[i]    <= w_db_cnt_d[i];
                r_pend_type_q[i] <= w_pend_type_d[i];
            end
            for (int k = 0; k < 8; k++) r_fifo_q[k] <= w_fifo_d[k];
        end
    end

    assign btn_state = r_state_q;
    assign evt_valid = (r_count_q != 4'd0);
    assign evt_data  = evt_valid ? r_fifo_q[r_rd_ptr_q] : 5'd0;
    assign evt_count = r_count_q;
    assign ovf       = r_ovf_q;

endmodule
`default_nettype wire
